// File: rtl/cnn_router_pkg.sv
// Shared types and address-width helpers for the CNN tile reader/router pair.
// No logic; constants and a width helper only.
// Not applicable (package).
package cnn_router_pkg;

  // Source buffer depth and the address width derived from it
  localparam int TR_BUF_DEPTH  = 64;
  localparam int TR_ADDR_WIDTH = $clog2(TR_BUF_DEPTH);

  // Router control states
  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_FILL  = 2'd1,
    TR_DRAIN = 2'd2
  } tr_state_e;

  // Index width for n entries, never narrower than one bit
  function automatic int tr_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_addr_decode.sv
// Maps a stream address to (row, col) inside a ROWS x COLS tile anchored at base.
// Latency: purely combinational.
// Backpressure: none; a pure function of its inputs.
module tile_addr_decode
  import cnn_router_pkg::*;
#(
  parameter int ADDR_WIDTH = TR_ADDR_WIDTH,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  localparam int ROW_W     = tr_idx_width(ROWS),
  localparam int COL_W     = tr_idx_width(COLS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [ROW_W-1:0]      row,
  output logic [COL_W-1:0]      col,
  output logic                  in_range
);

  localparam int TILE = ROWS * COLS;

  // Modular difference, so a tile may straddle the top of the address space
  logic [ADDR_WIDTH-1:0] offset;

  assign offset   = addr - base;
  assign in_range = (32'(offset) < TILE);
  // Row-major placement; row/col are meaningless when in_range is low
  assign row      = ROW_W'(offset / ADDR_WIDTH'(COLS));
  assign col      = COL_W'(offset % ADDR_WIDTH'(COLS));

endmodule

// File: rtl/tile_router.sv
// Collects one ROWS x COLS tile from the routing stream, then drains it column by column.
// Latency: element stored at the sampling edge; first column valid the cycle after fill completes.
// Backpressure: column data/index held while o_col_valid=1 and i_col_ready=0.
module tile_router
  import cnn_router_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BUF_DEPTH   = 64,
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  localparam int ADDR_WIDTH = $clog2(BUF_DEPTH),
  localparam int ROW_W      = tr_idx_width(ROWS),
  localparam int COL_W      = tr_idx_width(COLS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_reg_clear,
  input  logic                       i_route_en,
  input  logic [ADDR_WIDTH-1:0]      i_base_addr,
  input  logic                       i_valid,
  input  logic [ADDR_WIDTH-1:0]      i_data_addr,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_read_done,
  input  logic                       i_col_ready,
  output logic                       o_col_valid,
  output logic [ROWS*DATA_WIDTH-1:0] o_col_data,
  output logic [COL_W-1:0]           o_col_idx,
  output logic                       o_route_done,
  output logic                       o_busy,
  output logic                       o_err
);

  tr_state_e                  state;
  logic [DATA_WIDTH-1:0]      mem [ROWS][COLS];
  logic [ROWS-1:0][COLS-1:0]  bitmap;
  logic [ROWS-1:0][COLS-1:0]  bitmap_nxt;

  logic [ROW_W-1:0]           dec_row;
  logic [COL_W-1:0]           dec_col;
  logic                       dec_in_range;
  logic                       wr_en;

  tile_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROWS       (ROWS),
    .COLS       (COLS)
  ) u_decode (
    .addr     (i_data_addr),
    .base     (i_base_addr),
    .row      (dec_row),
    .col      (dec_col),
    .in_range (dec_in_range)
  );

  assign wr_en = (state == TR_FILL) && i_valid && dec_in_range;

  // Bitmap including this cycle's write, so a last-slot write beats a same-cycle read_done
  always_comb begin
    bitmap_nxt = bitmap;
    if (wr_en) begin
      bitmap_nxt[dec_row][dec_col] = 1'b1;
    end
  end

  // Control FSM, tile storage, fill bitmap and column counter
  always_ff @(posedge i_clk) begin
    if (i_rst || i_reg_clear) begin
      state        <= TR_IDLE;
      o_col_valid  <= 1'b0;
      o_route_done <= 1'b0;
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
      o_col_idx    <= '0;
      bitmap       <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else begin
      o_route_done <= 1'b0;
      case (state)
        TR_IDLE: begin
          if (i_route_en) begin
            state     <= TR_FILL;
            o_busy    <= 1'b1;
            o_col_idx <= '0;
            bitmap    <= '0;
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) begin
                mem[r][c] <= '0;
              end
            end
          end
        end

        TR_FILL: begin
          if (wr_en) begin
            mem[dec_row][dec_col] <= i_data;
          end
          bitmap <= bitmap_nxt;
          if (i_valid && !dec_in_range) begin
            o_err <= 1'b1;
          end
          if (&bitmap_nxt) begin
            state       <= TR_DRAIN;
            o_col_valid <= 1'b1;
          end else if (i_read_done) begin
            // Underrun: drain what arrived, unfilled slots stay zero
            state       <= TR_DRAIN;
            o_col_valid <= 1'b1;
            o_err       <= 1'b1;
          end
        end

        TR_DRAIN: begin
          if (i_col_ready) begin
            if (o_col_idx == COL_W'(COLS - 1)) begin
              state        <= TR_IDLE;
              o_col_valid  <= 1'b0;
              o_busy       <= 1'b0;
              o_route_done <= 1'b1;
              o_col_idx    <= '0;
            end else begin
              o_col_idx <= o_col_idx + 1'b1;
            end
          end
        end

        default: state <= TR_IDLE;
      endcase
    end
  end

  // Present the column selected by the registered index
  always_comb begin
    o_col_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      o_col_data[r*DATA_WIDTH +: DATA_WIDTH] = mem[r][o_col_idx];
    end
  end

endmodule

// File: tb/tb_tile_router.sv
// Directed scoreboard bench for tile_router.
// Latency: checks fill-to-drain and last-accept-to-done timing.
// Backpressure: exercises i_col_ready toggling during drain.
module tb_tile_router;

  localparam int DW   = 8;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_reg_clear;
  logic        i_route_en;
  logic [5:0]  i_base_addr;
  logic        i_valid;
  logic [5:0]  i_data_addr;
  logic [7:0]  i_data;
  logic        i_read_done;
  logic        i_col_ready;
  logic        o_col_valid;
  logic [31:0] o_col_data;
  logic [1:0]  o_col_idx;
  logic        o_route_done;
  logic        o_busy;
  logic        o_err;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb [$];
  logic [7:0]  mdl [ROWS][COLS];
  int          base_i;

  tile_router dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_reg_clear  (i_reg_clear),
    .i_route_en   (i_route_en),
    .i_base_addr  (i_base_addr),
    .i_valid      (i_valid),
    .i_data_addr  (i_data_addr),
    .i_data       (i_data),
    .i_read_done  (i_read_done),
    .i_col_ready  (i_col_ready),
    .o_col_valid  (o_col_valid),
    .o_col_data   (o_col_data),
    .o_col_idx    (o_col_idx),
    .o_route_done (o_route_done),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tile(input int b);
    base_i      = b;
    i_base_addr = 6'(b);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mdl[r][c] = 8'h00;
    i_route_en = 1'b1;
    @(posedge i_clk); #1;
    i_route_en = 1'b0;
    @(negedge i_clk);
    check("busy_after_en", o_busy, 1);
    check("no_valid_in_fill", o_col_valid, 0);
    @(posedge i_clk); #1;
  endtask

  task automatic send(input int a, input logic [7:0] d, input bit done);
    int off;
    i_valid     = 1'b1;
    i_data_addr = 6'(a);
    i_data      = d;
    i_read_done = done;
    off = (a - base_i + 64) % 64;
    if (off < ROWS * COLS) mdl[off / COLS][off % COLS] = d;
    @(posedge i_clk); #1;
    i_valid     = 1'b0;
    i_read_done = 1'b0;
  endtask

  task automatic push_model();
    for (int c = 0; c < COLS; c++)
      sb.push_back({mdl[3][c], mdl[2][c], mdl[1][c], mdl[0][c]});
  endtask

  // Accept n columns; bp selects the 1,0,0,1 ready pattern
  task automatic drain(input int n, input bit bp);
    int          acc  = 0;
    int          cyc  = 0;
    int          k    = 0;
    bit          held = 1'b0;
    logic [31:0] pd;
    logic [1:0]  pi;
    logic [31:0] e;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (acc < n && cyc < 200) begin
      i_col_ready = bp ? pat[k % 4] : 1'b1;
      k++;
      @(negedge i_clk);
      if (held) begin
        check("hold_data", o_col_data, pd);
        check("hold_idx", o_col_idx, pi);
      end
      held = 1'b0;
      if (o_col_valid) begin
        if (i_col_ready) begin
          e = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
          check("col_data", o_col_data, e);
          check("col_idx", o_col_idx, acc);
          acc++;
        end else begin
          held = 1'b1;
          pd   = o_col_data;
          pi   = o_col_idx;
        end
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_col_ready = 1'b0;
    check("cols_accepted", acc, n);
    if (n == COLS) begin
      @(negedge i_clk);
      check("route_done_pulse", o_route_done, 1);
      check("busy_after_done", o_busy, 0);
      check("valid_after_done", o_col_valid, 0);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      check("route_done_single", o_route_done, 0);
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    i_rst       = 1'b1;
    i_reg_clear = 1'b0;
    i_route_en  = 1'b0;
    i_base_addr = '0;
    i_valid     = 1'b0;
    i_data_addr = '0;
    i_data      = '0;
    i_read_done = 1'b0;
    i_col_ready = 1'b0;
    base_i      = 0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_valid", o_col_valid, 0);
    check("rst_done", o_route_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_idx", o_col_idx, 0);
    @(posedge i_clk); #1;

    // Happy path: base 8, addrs 8..23, data = addr
    start_tile(8);
    for (int a = 8; a < 24; a++) send(a, 8'(a), 1'b0);
    for (int c = 0; c < COLS; c++)
      sb.push_back({8'(20 + c), 8'(16 + c), 8'(12 + c), 8'(8 + c)});
    drain(4, 1'b0);
    check("happy_err", o_err, 0);

    // Duplicate of addr 8, others reversed, with backpressure during drain
    start_tile(8);
    send(8, 8'hAA, 1'b0);
    send(8, 8'h55, 1'b0);
    for (int a = 23; a >= 10; a--) send(a, 8'(a), 1'b0);
    @(negedge i_clk);
    check("dup_not_full", o_col_valid, 0);
    check("dup_still_busy", o_busy, 1);
    @(posedge i_clk); #1;
    send(9, 8'd9, 1'b0);
    push_model();
    drain(4, 1'b1);

    // Wrap-around base 60; last slot coincides with read_done
    start_tile(60);
    for (int i = 0; i < 16; i++) send((60 + i) % 64, 8'(((60 + i) % 64) ^ 8'h5A), i == 15);
    @(negedge i_clk);
    check("wrap_valid", o_col_valid, 1);
    check("wrap_no_err", o_err, 0);
    check("wrap_r1c0", o_col_data[15:8], 8'h5A);
    @(posedge i_clk); #1;
    push_model();
    drain(4, 1'b0);

    // Out-of-range element then underrun after 10 elements
    start_tile(8);
    send(40, 8'hEE, 1'b0);
    @(negedge i_clk);
    check("oor_err", o_err, 1);
    check("oor_no_valid", o_col_valid, 0);
    @(posedge i_clk); #1;
    for (int a = 8; a < 18; a++) send(a, 8'(a + 1), 1'b0);
    i_read_done = 1'b1;
    @(posedge i_clk); #1;
    i_read_done = 1'b0;
    @(negedge i_clk);
    check("underrun_valid", o_col_valid, 1);
    check("underrun_err", o_err, 1);
    @(posedge i_clk); #1;
    push_model();
    drain(4, 1'b0);

    // Clear after column 1 accepted
    start_tile(0);
    for (int a = 0; a < 16; a++) send(a, 8'($urandom_range(255)), 1'b0);
    push_model();
    drain(2, 1'b0);
    i_reg_clear = 1'b1;
    @(posedge i_clk); #1;
    i_reg_clear = 1'b0;
    @(negedge i_clk);
    check("clr_valid", o_col_valid, 0);
    check("clr_busy", o_busy, 0);
    check("clr_err", o_err, 0);
    check("clr_done", o_route_done, 0);
    check("clr_idx", o_col_idx, 0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("clr_no_late_done", o_route_done, 0);
    @(posedge i_clk); #1;
    sb.delete();

    // Fresh tile after clear
    start_tile(16);
    for (int a = 16; a < 32; a++) send(a, 8'($urandom_range(255)), 1'b0);
    push_model();
    drain(4, 1'b0);
    check("fresh_err", o_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_router.md
# tile_router

Downstream consumer of the tile reader's routing stream (data, data address, valid). Collects one ROWS×COLS tile into a local register array, indexed by each element's address relative to a tile base address. Once the tile is complete, or the reader reports done, it drains the tile column by column over a valid/ready handshake into the PE array input skew stage.

## Interface
- DATA_WIDTH, 8, element width
- BUF_DEPTH, 64, source buffer depth
- ADDR_WIDTH, $clog2(BUF_DEPTH), localparam, address width
- ROWS, 4, tile rows; also the width of the output column vector
- COLS, 4, tile columns; ROWS*COLS ≤ BUF_DEPTH

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_reg_clear  in  1  synchronous soft clear
- i_route_en  in  1  arm for one tile; sampled only in IDLE
- i_base_addr  in  ADDR_WIDTH  address of tile element (0,0)
- i_valid  in  1  stream element valid
- i_data_addr  in  ADDR_WIDTH  stream element address
- i_data  in  DATA_WIDTH  stream element
- i_read_done  in  1  upstream finished reading
- i_col_ready  in  1  downstream accepts a column
- o_col_valid  out  1  column data valid
- o_col_data  out  ROWS*DATA_WIDTH  row r in bits [r*DATA_WIDTH +: DATA_WIDTH]
- o_col_idx  out  $clog2(COLS) (min 1)  index of the presented column
- o_route_done  out  1  one-cycle pulse after the last column is accepted
- o_busy  out  1  state ≠ IDLE
- o_err  out  1  sticky; out-of-range address or underrun

## Operation
- States: IDLE, FILL, DRAIN.
- IDLE:
  - i_route_en → FILL.
  - On entry to FILL: clear the array to zero, the valid bitmap, and the column counter. o_err is not cleared.
- FILL:
  - Element accepted when i_valid=1.
  - Offset = (i_data_addr − i_base_addr) mod 2^ADDR_WIDTH.
  - row = offset / COLS, col = offset % COLS (row-major).
  - Offset ≥ ROWS*COLS: element dropped, o_err ← 1.
  - In-range element: written to the array and its bitmap bit set. A duplicate address overwrites the slot without double-counting.
  - Bitmap all-ones → DRAIN.
  - i_read_done=1 with the bitmap not full → DRAIN, o_err ← 1. Missing slots drain as zero.
  - If the final slot is written in the same cycle as i_read_done: tile is full, no error.
- DRAIN:
  - o_col_valid=1 and o_col_data = array column o_col_idx.
  - On a cycle with o_col_valid & i_col_ready, o_col_idx increments.
  - Acceptance of column COLS−1 → o_route_done pulses the next cycle, state → IDLE.
  - o_col_data and o_col_idx are held stable while o_col_valid=1 and i_col_ready=0.
- Inputs ignored outside their states:
  - i_valid in IDLE and DRAIN.
  - i_route_en outside IDLE.
- Priority: i_rst > i_reg_clear > everything else. i_reg_clear has the same effect as reset, including o_err.

## Timing
- Reset or clear values: state IDLE; o_col_valid, o_route_done, o_busy, o_err, o_col_idx all 0; array and bitmap 0.
- o_busy=1 the cycle after i_route_en is sampled in IDLE.
- An element sampled at edge N is stored at edge N.
- Fill completes at edge N → o_col_valid=1 from cycle N+1.
- With i_col_ready held high: one column per cycle. The last column is accepted at edge M; o_route_done=1 and o_busy=0 during cycle M+1.
- Minimum tile latency with ready always high: fill cycles + COLS + 1.
- A reset or clear mid-FILL or mid-DRAIN aborts the tile. No o_route_done is issued.
- All outputs are registered; no combinational input→output paths except none. o_col_data comes from the registered array muxed by the registered o_col_idx.

## Structure
- Package cnn_router_pkg:
  - state enum tr_state_e {TR_IDLE, TR_FILL, TR_DRAIN}
  - shared ADDR_WIDTH helper constants (also used by the tile reader)
- Sub-module tile_addr_decode: purely combinational. Maps (addr, base) to {row, col, in_range}. Reused by the weight-side router.
- tile_router holds the FSM, the ROWS×COLS register array, the bitmap, and the column counter.

## Test plan
- Happy path: base=8, stream addrs 8..23 in order with data = addr → columns c=0..3 drain as {8+c, 12+c, 16+c, 20+c}; o_route_done pulses once; o_err=0.
- Scrambled and duplicate addresses: addr 8 sent twice (data 0xAA then 0x55) plus all others in reverse order → slot (0,0)=0x55; DRAIN entered only after all 16 distinct addresses.
- Backpressure: i_col_ready toggling 1,0,0,1 … → each column held stable while ready=0; 4 columns total; no skipped or repeated o_col_idx.
- Out-of-range and underrun: addr 40 with base 8 → o_err=1, element dropped. i_read_done after 10 valid elements → DRAIN with the 6 missing slots = 0.
- Wrap-around: base=60, addrs 60..63 and 0..11 → correct row-major placement (addr 0 → row 1, col 0).
- Clear mid-DRAIN: i_reg_clear after column 1 accepted → next cycle o_col_valid=0, o_busy=0, o_err=0, no o_route_done; a new i_route_en starts a fresh tile.
